mxv_row_group_scheduler: RTL

- Sequences the matrix-by-vector datapath for one full matrix-vector product.
- Splits N matrix rows into groups of P and issues a row-descriptor memory read per group.
- Pulses lane starts to the P row-by-vector lanes, collects each lane's result as it completes, and writes the packed group result to the result memory.
- Sits between the solver top-level FSM (command handshake) and the P row_by_vector lanes plus their row/result memories.

---
 rtl/mxv_row_group_scheduler_if.sv | 41 ++++
 rtl/mxv_row_group_scheduler.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mxv_row_group_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mxv_row_group_scheduler_if                                                 |
// | Command, descriptor-read, lane and result-write signals of the scheduler.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface mxv_row_group_scheduler_if #(
  parameter int P      = 4,
  parameter int ELEM_W = 32,
  parameter int ADDR_W = 10
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [31:0]           cmd_rows;
  logic [ADDR_W-1:0]     cmd_base;
  logic [ADDR_W-1:0]     cmd_res_base;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [P-1:0]          lane_start;
  logic [P-1:0]          lane_done;
  logic [P*ELEM_W-1:0]   lane_result;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [P*ELEM_W-1:0]   wr_data;
  logic                  busy;
  logic                  done;
  logic [15:0]           group_idx;

  modport slave (
    input  cmd_valid, cmd_rows, cmd_base, cmd_res_base, lane_done, lane_result,
    output cmd_ready, rd_en, rd_addr, lane_start, wr_en, wr_addr, wr_data,
           busy, done, group_idx
  );

  modport master (
    output cmd_valid, cmd_rows, cmd_base, cmd_res_base, lane_done, lane_result,
    input  cmd_ready, rd_en, rd_addr, lane_start, wr_en, wr_addr, wr_data,
           busy, done, group_idx
  );
endinterface
`default_nettype wire

// File: rtl/mxv_row_group_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mxv_row_group_scheduler                                                    |
// | Walks N rows in groups of P: fetch, launch lanes, gather, write, repeat.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mxv_row_group_scheduler #(
  parameter int P      = 4,
  parameter int ELEM_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  mxv_row_group_scheduler_if.slave bus
);
  localparam int DW = P * ELEM_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_MEMWAIT = 3'd2,
    S_LAUNCH  = 3'd3,
    S_RUN     = 3'd4,
    S_WRITE   = 3'd5,
    S_FIN     = 3'd6
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_rows, w_rows_nxt;
  logic [ADDR_W-1:0] r_base, w_base_nxt;
  logic [ADDR_W-1:0] r_res_base, w_res_base_nxt;
  logic [31:0]       r_groups, w_groups_nxt;
  logic [31:0]       r_group_idx, w_group_idx_nxt;
  logic [P-1:0]      r_done_mask, w_done_mask_nxt;
  logic [DW-1:0]     r_results, w_results_nxt;

  logic [31:0]       w_row_first;
  logic [31:0]       w_cmd_groups;
  logic [P-1:0]      w_active;

  logic              w_cmd_ready;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [P-1:0]      w_lane_start;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DW-1:0]     w_wr_data;
  logic              w_busy;
  logic              w_done;

  // ceil(N/P) without the overflow that (N+P-1)/P would hit near 2^32
  assign w_cmd_groups = (bus.cmd_rows / 32'(P)) +
                        {31'd0, ((bus.cmd_rows % 32'(P)) != 32'd0)};
  assign w_row_first  = r_group_idx * 32'(P);

  generate
    for (genvar k = 0; k < P; k++) begin : g_active
      assign w_active[k] = (w_row_first + 32'(k)) < r_rows;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rows      <= 32'd0;
      r_base      <= '0;
      r_res_base  <= '0;
      r_groups    <= 32'd0;
      r_group_idx <= 32'd0;
      r_done_mask <= '0;
      r_results   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rows      <= w_rows_nxt;
      r_base      <= w_base_nxt;
      r_res_base  <= w_res_base_nxt;
      r_groups    <= w_groups_nxt;
      r_group_idx <= w_group_idx_nxt;
      r_done_mask <= w_done_mask_nxt;
      r_results   <= w_results_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_rows_nxt      = r_rows;
    w_base_nxt      = r_base;
    w_res_base_nxt  = r_res_base;
    w_groups_nxt    = r_groups;
    w_group_idx_nxt = r_group_idx;
    w_done_mask_nxt = r_done_mask;
    w_results_nxt   = r_results;
    w_cmd_ready     = 1'b0;
    w_rd_en         = 1'b0;
    w_rd_addr       = '0;
    w_lane_start    = '0;
    w_wr_en         = 1'b0;
    w_wr_addr       = '0;
    w_wr_data       = '0;
    w_busy          = 1'b0;
    w_done          = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_rows_nxt      = bus.cmd_rows;
          w_base_nxt      = bus.cmd_base;
          w_res_base_nxt  = bus.cmd_res_base;
          w_groups_nxt    = w_cmd_groups;
          w_group_idx_nxt = 32'd0;
          w_state_nxt     = (bus.cmd_rows == 32'd0) ? S_FIN : S_FETCH;
        end
      end
      S_FETCH: begin
        w_busy      = 1'b1;
        w_rd_en     = 1'b1;
        w_rd_addr   = r_base + r_group_idx[ADDR_W-1:0];
        w_state_nxt = S_MEMWAIT;
      end
      S_MEMWAIT: begin
        w_busy      = 1'b1;
        w_state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        // Inactive lanes are pre-marked done so RUN only waits on real rows
        w_busy          = 1'b1;
        w_lane_start    = w_active;
        w_done_mask_nxt = ~w_active;
        w_results_nxt   = '0;
        w_state_nxt     = S_RUN;
      end
      S_RUN: begin
        w_busy = 1'b1;
        for (int k = 0; k < P; k++) begin
          if (bus.lane_done[k] && !r_done_mask[k]) begin
            w_done_mask_nxt[k]                 = 1'b1;
            w_results_nxt[k*ELEM_W +: ELEM_W] = bus.lane_result[k*ELEM_W +: ELEM_W];
          end
        end
        if (&w_done_mask_nxt) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        w_busy    = 1'b1;
        w_wr_en   = 1'b1;
        w_wr_addr = r_res_base + r_group_idx[ADDR_W-1:0];
        w_wr_data = r_results;
        if (r_group_idx == r_groups - 32'd1) begin
          w_state_nxt = S_FIN;
        end else begin
          w_group_idx_nxt = r_group_idx + 32'd1;
          w_state_nxt     = S_FETCH;
        end
      end
      S_FIN: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.rd_en      = w_rd_en;
  assign bus.rd_addr    = w_rd_addr;
  assign bus.lane_start = w_lane_start;
  assign bus.wr_en      = w_wr_en;
  assign bus.wr_addr    = w_wr_addr;
  assign bus.wr_data    = w_wr_data;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.group_idx  = r_group_idx[15:0];

endmodule
`default_nettype wire
